instr_queue: RTL and testbench

Instruction queue between the fetch stage and decode. Accepts the 64-bit response beats of each 64-byte fetch line (8 beats) and splits every beat into two 32-bit instructions, low word first. Tags each instruction with its PC and buffers it in a FIFO drained by decode through a valid/ready handshake. Detects the all-zero end-of-program word and raises a sticky halt.

---
 rtl/instr_queue_pkg.sv | 13 +
 rtl/instr_fifo.sv | 54 +++++
 rtl/instr_queue.sv | 126 ++++++++++++
 tb/tb_instr_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_queue_pkg.sv
// instr_queue shared types and constants.
package instr_queue_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam int INSTR_W        = 32;
  localparam int PC_STEP        = 4;
  localparam int BEATS_PER_LINE = 8;
  localparam int ENTRY_W        = 64 + INSTR_W;
endpackage

// File: rtl/instr_fifo.sv
// Instruction FIFO: {pc, instr} entries, dual write
// (slot, slot+1), single read, occupancy counter.
module instr_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 96
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_wr0,
  input  logic [W-1:0]               i_wr0_data,
  input  logic                       i_wr1,
  input  logic [W-1:0]               i_wr1_data,
  input  logic                       i_rd,
  output logic [W-1:0]               o_rd_data,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] w_wptr1;
  logic [1:0]    w_nwr;

  assign w_wptr1 = r_wptr + AW'(1);
  assign w_nwr   = {1'b0, i_wr0} + {1'b0, i_wr1};

  always_ff @(posedge clk) begin
    if (i_wr0) r_mem[r_wptr]  <= i_wr0_data;
    if (i_wr1) r_mem[w_wptr1] <= i_wr1_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= r_wptr + AW'(w_nwr);
      r_rptr  <= r_rptr + AW'(i_rd);
      r_count <= r_count + CW'(w_nwr) - CW'(i_rd);
    end
  end

  assign o_rd_data = r_mem[r_rptr];
  assign o_count   = r_count;
endmodule

// File: rtl/instr_queue.sv
// Fetch-to-decode instruction queue: splits 64-bit beats
// into PC-tagged instructions, halts on an all-zero word.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DEPTH          = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      burst_start,
  input  logic [63:0]               burst_pc,
  input  logic                      beat_valid,
  input  logic [BUS_DATA_WIDTH-1:0] beat_data,
  output logic                      beat_ready,
  output logic                      line_done,
  output logic                      instr_valid,
  output logic [31:0]               instr,
  output logic [63:0]               instr_pc,
  input  logic                      instr_ready,
  input  logic                      flush,
  output logic                      halt,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int BLW = $clog2(BEATS_PER_LINE) + 1;

  state_t           r_state;
  logic [63:0]      r_pc;
  logic [BLW-1:0]   r_left;

  logic [31:0]        w_lo;
  logic [31:0]        w_hi;
  logic               w_room;
  logic               w_acc;
  logic               w_s_acc;
  logic               w_wr0;
  logic               w_wr1;
  logic               w_halting;
  logic               w_last;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;

  assign w_lo   = beat_data[31:0];
  assign w_hi   = beat_data[63:32];
  // Same-cycle pops are not credited: room is judged on current count.
  assign w_room = (count <= CW'(DEPTH - 2));

  always_comb begin
    beat_ready = 1'b0;
    unique case (r_state)
      STREAM:  beat_ready = w_room;
      HALT:    beat_ready = 1'b1;
      default: beat_ready = 1'b0;
    endcase
  end

  assign w_acc     = beat_valid && beat_ready;
  assign w_s_acc   = w_acc && (r_state == STREAM) && !flush;
  assign w_wr0     = w_s_acc && (w_lo != '0);
  assign w_wr1     = w_wr0 && (w_hi != '0);
  assign w_halting = w_s_acc && ((w_lo == '0) || (w_hi == '0));
  assign w_last    = w_acc && (r_left == BLW'(1));
  assign line_done = w_last && !flush;
  assign w_pop     = instr_valid && instr_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_left  <= '0;
    end else if (flush) begin
      r_state <= IDLE;
      r_left  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (burst_start) begin
            r_state <= STREAM;
            r_pc    <= burst_pc;
            r_left  <= BLW'(BEATS_PER_LINE);
          end
        end
        STREAM: begin
          if (w_acc) begin
            r_left <= r_left - BLW'(1);
            r_pc   <= r_pc + 64'(2 * PC_STEP);
            if (w_halting)   r_state <= HALT;
            else if (w_last) r_state <= IDLE;
          end
          // A new line request abandons the rest of the current one.
          if (burst_start && !w_halting) begin
            r_state <= STREAM;
            r_pc    <= burst_pc;
            r_left  <= BLW'(BEATS_PER_LINE);
          end
        end
        HALT: begin
          if (w_acc && (r_left != '0)) r_left <= r_left - BLW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  instr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (flush),
    .i_wr0      (w_wr0),
    .i_wr0_data ({r_pc, w_lo}),
    .i_wr1      (w_wr1),
    .i_wr1_data ({r_pc + 64'(PC_STEP), w_hi}),
    .i_rd       (w_pop),
    .o_rd_data  (w_head),
    .o_count    (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? w_head[31:0]  : '0;
  assign instr_pc    = instr_valid ? w_head[95:32] : '0;
  assign halt        = (r_state == HALT);
endmodule

// File: tb/tb_instr_queue.sv
// Randomized bench for instr_queue against a queue-based
// reference model of the fetch/decode instruction stream.
module tb_instr_queue;
  logic        clk = 1'b0;
  logic        reset;
  logic        burst_start;
  logic [63:0] burst_pc;
  logic        beat_valid;
  logic [63:0] beat_data;
  logic        beat_ready;
  logic        line_done;
  logic        instr_valid;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_ready;
  logic        flush;
  logic        halt;
  logic [4:0]  count;

  instr_queue #(.BUS_DATA_WIDTH(64), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .burst_start (burst_start),
    .burst_pc    (burst_pc),
    .beat_valid  (beat_valid),
    .beat_data   (beat_data),
    .beat_ready  (beat_ready),
    .line_done   (line_done),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .flush       (flush),
    .halt        (halt),
    .count       (count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [95:0] q[$];
  logic [63:0] m_pc;
  int          m_left;
  logic        m_halted;
  logic        last_acc;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc     = '0;
    m_left   = 0;
    m_halted = 1'b0;
    last_acc = 1'b0;
  endtask

  task automatic cyc(input logic bs, input logic [63:0] bpc,
                     input logic bv, input logic [63:0] bd,
                     input logic ir, input logic fl);
    logic        rdy;
    logic        acc;
    logic        ld;
    logic [31:0] lo;
    logic [31:0] hi;
    @(negedge clk);
    chk("count", 64'(count), 64'(q.size()));
    chk("valid", 64'(instr_valid), 64'(q.size() != 0));
    chk("halt", 64'(halt), 64'(m_halted));
    if (q.size() != 0) begin
      chk("instr", 64'(instr), 64'(q[0][31:0]));
      chk("ipc", instr_pc, q[0][95:32]);
    end else begin
      chk("instr0", 64'(instr), 64'd0);
      chk("ipc0", instr_pc, 64'd0);
    end
    burst_start = bs;
    burst_pc    = bpc;
    beat_valid  = bv;
    beat_data   = bd;
    instr_ready = ir;
    flush       = fl;
    #1;
    rdy = m_halted ? 1'b1 : ((m_left > 0) && (16 - q.size() >= 2));
    acc = bv && rdy;
    ld  = acc && (m_left == 1) && !fl;
    chk("beat_ready", 64'(beat_ready), 64'(rdy));
    chk("line_done", 64'(line_done), 64'(ld));
    last_acc = acc && !fl;
    if (fl) begin
      q.delete();
      m_left   = 0;
      m_halted = 1'b0;
    end else begin
      if (ir && q.size() != 0) void'(q.pop_front());
      if (m_halted) begin
        if (acc && m_left > 0) m_left--;
      end else if (m_left > 0) begin
        if (acc) begin
          m_left--;
          lo = bd[31:0];
          hi = bd[63:32];
          if (lo == 0) m_halted = 1'b1;
          else begin
            q.push_back({m_pc, lo});
            if (hi == 0) m_halted = 1'b1;
            else q.push_back({m_pc + 64'd4, hi});
          end
          m_pc = m_pc + 64'd8;
        end
        if (bs && !m_halted) begin
          m_pc   = bpc;
          m_left = 8;
        end
      end else if (bs) begin
        m_pc   = bpc;
        m_left = 8;
      end
    end
  endtask

  task automatic idle(input int n, input logic ir);
    repeat (n) cyc(1'b0, 64'd0, 1'b0, 64'd0, ir, 1'b0);
  endtask

  // Offer beats, holding each until accepted; zat selects a special beat.
  task automatic send(input int n, input logic ir, input int zat,
                      input logic [63:0] zval);
    int          sent;
    int          guard;
    logic [63:0] d;
    sent  = 0;
    guard = 0;
    while (sent < n && guard < 200) begin
      d = {32'h8000_0000 + 32'(2 * sent + 1), 32'h4000_0000 + 32'(2 * sent)};
      if (sent == zat) d = zval;
      cyc(1'b0, 64'd0, 1'b1, d, ir, 1'b0);
      if (last_acc) sent++;
      guard++;
    end
    chk("beats_sent", 64'(sent), 64'(n));
  endtask

  initial begin
    logic [63:0] d;
    logic [63:0] pc;
    int          r;
    reset = 1'b1;
    burst_start = 1'b0;
    burst_pc    = '0;
    beat_valid  = 1'b0;
    beat_data   = '0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    model_reset();
    #2;
    chk("rst_ready", 64'(beat_ready), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_halt", 64'(halt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full line streamed straight through to decode.
    cyc(1'b1, 64'h1000, 1'b0, 64'd0, 1'b1, 1'b0);
    send(8, 1'b1, -1, 64'd0);
    idle(20, 1'b1);
    chk("t1_empty", 64'(count), 64'd0);

    // Fill to capacity, stall, then resume.
    cyc(1'b1, 64'h4000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(8, 1'b0, -1, 64'd0);
    cyc(1'b1, 64'h5000, 1'b0, 64'd0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 64'd0, 1'b1, 64'h1111_1111_2222_2222, 1'b0, 1'b0);
    chk("t2_full", 64'(count), 64'd16);
    chk("t2_stall", 64'(beat_ready), 64'd0);
    send(8, 1'b1, -1, 64'd0);
    idle(20, 1'b1);

    // High word zero on beat 3 halts; remaining beats drain.
    cyc(1'b1, 64'h8000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(8, 1'b0, 2, 64'h0000_0000_0000_0013);
    idle(1, 1'b0);
    chk("t3_halt", 64'(halt), 64'd1);
    chk("t3_count", 64'(count), 64'd5);
    chk("t3_last_pc", q[4][95:32], 64'h8010);
    idle(8, 1'b1);
    cyc(1'b1, 64'h8800, 1'b1, 64'h1, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("t3_ign_burst", 64'(count), 64'd0);

    // Low word zero halts; flush clears.
    cyc(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
    cyc(1'b1, 64'h9000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(1, 1'b0, 0, 64'h0000_0077_0000_0000);
    idle(1, 1'b0);
    chk("t4_halt", 64'(halt), 64'd1);
    cyc(1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b1);
    idle(1, 1'b0);
    chk("t4_unhalt", 64'(halt), 64'd0);
    chk("t4_count", 64'(count), 64'd0);

    // Flush beats a same-cycle beat and pop.
    cyc(1'b1, 64'hA000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(3, 1'b0, -1, 64'd0);
    idle(1, 1'b0);
    chk("t5_six", 64'(count), 64'd6);
    cyc(1'b0, 64'd0, 1'b1, 64'h3333_3333_4444_4444, 1'b1, 1'b1);
    idle(1, 1'b0);
    chk("t5_flushed", 64'(count), 64'd0);

    // Asynchronous reset between clock edges, mid-line.
    cyc(1'b1, 64'hB000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(2, 1'b0, -1, 64'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 64'(count), 64'd0);
    chk("ar_valid", 64'(instr_valid), 64'd0);
    chk("ar_instr", 64'(instr), 64'd0);
    chk("ar_pc", instr_pc, 64'd0);
    chk("ar_halt", 64'(halt), 64'd0);
    chk("ar_ready", 64'(beat_ready), 64'd0);
    chk("ar_ld", 64'(line_done), 64'd0);
    burst_start = 1'b0;
    beat_valid  = 1'b0;
    instr_ready = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    cyc(1'b1, 64'h2000, 1'b0, 64'd0, 1'b0, 1'b0);
    send(1, 1'b0, -1, 64'd0);
    idle(1, 1'b0);
    chk("ar_newpc", instr_pc, 64'h2000);

    // Random traffic, including PC wrap near the top of memory.
    repeat (3000) begin
      r  = $urandom_range(0, 49);
      d  = {$urandom(), $urandom()};
      if (r == 0) d[31:0] = '0;
      if (r == 1) d[63:32] = '0;
      pc = {$urandom(), $urandom()} & ~64'h3F;
      if ($urandom_range(0, 7) == 0) pc = 64'hFFFF_FFFF_FFFF_FFC0;
      cyc($urandom_range(0, 9) == 0, pc, $urandom_range(0, 9) < 6, d,
          $urandom_range(0, 1) == 1, $urandom_range(0, 32) == 0);
    end
    idle(20, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
